// File: rtl/mem_ctrl_spi_pkg.sv
// Shared types for the SPI memory responder.
// Op/select enums, SPI command bytes and FSM states.
package mem_ctrl_spi_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;

  typedef enum logic {
    PC  = 1'b0,
    MAR = 1'b1
  } addr_sel_e;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         FRAME_BITS    = 40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    RELEASE
  } mem_ctrl_spi_state;

endpackage

// File: rtl/mem_ctrl_spi_if.sv
// Request/done bus between the CPU control FSM
// and the SPI memory responder.
interface mem_ctrl_spi_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 8
);
  import mem_ctrl_spi_pkg::*;

  mem_ctrl_op_e              mem_ctrl_op;
  addr_sel_e                 addr_sel;
  logic [ADDR_WIDTH-1:0]     pc_addr;
  logic [ADDR_WIDTH-1:0]     mar_addr;
  logic [DATA_BUS_WIDTH-1:0] data_in;
  logic [DATA_BUS_WIDTH-1:0] data_out;
  logic                      mem_op_done;

  modport master (
    output mem_ctrl_op, addr_sel,
    output pc_addr, mar_addr, data_in,
    input  data_out, mem_op_done
  );

  modport slave (
    input  mem_ctrl_op, addr_sel,
    input  pc_addr, mar_addr, data_in,
    output data_out, mem_op_done
  );

endinterface

// File: rtl/mem_ctrl_spi_shift_engine.sv
// Mode-0 SPI shifter: 40-bit TX frame out, MISO sampled
// into an 8-bit RX register, SCK half-period CLK_DIV.
module spi_shift_engine
  import mem_ctrl_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  busy,
  output logic                  last,
  output logic                  sck,
  output logic                  mosi,
  output logic [7:0]            rx
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]         div_cnt;
  logic [FRAME_BITS-1:0] tx;
  logic [5:0]            bit_cnt;
  logic                  tick;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));
  assign last = busy & sck & tick &
                (bit_cnt == 6'(FRAME_BITS - 1));

  // tx holds the bits still to send, next one at the MSB
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      sck     <= 1'b0;
      mosi    <= frame[FRAME_BITS-1];
      tx      <= {frame[FRAME_BITS-2:0], 1'b0};
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (busy) begin
      if (!tick) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
          rx  <= {rx[6:0], miso};
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 6'(FRAME_BITS - 1)) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
            mosi    <= tx[FRAME_BITS-1];
            tx      <= {tx[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_spi.sv
// SPI memory responder: PC reads flash, MAR reads/writes
// RAM, one framed transaction per request, done pulse.
module mem_ctrl_spi
  import mem_ctrl_spi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int CLK_DIV        = 1
) (
  input  logic           clock,
  input  logic           reset,
  mem_ctrl_spi_if.slave  bus,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic           spi_cs_flash_n,
  output logic           spi_cs_ram_n
);

  mem_ctrl_spi_state state, state_n;
  mem_ctrl_op_e      op_q, op_n;
  addr_sel_e         sel_q, sel_n;

  logic                      start, busy, last;
  logic                      mosi_raw;
  logic [7:0]                rx;
  logic [7:0]                cmd;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [FRAME_BITS-1:0]     frame;
  logic                      done_q;
  logic [DATA_BUS_WIDTH-1:0] dout_q;

  assign addr  = (bus.addr_sel == MAR) ? bus.mar_addr
                                       : bus.pc_addr;
  assign cmd   = (bus.mem_ctrl_op == MEM_WRITE)
               ? SPI_CMD_WRITE : SPI_CMD_READ;
  assign frame = {cmd, {(24-ADDR_WIDTH){1'b0}}, addr,
                  bus.data_in};

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clock (clock),
    .reset (reset),
    .start (start),
    .frame (frame),
    .miso  (spi_miso),
    .busy  (busy),
    .last  (last),
    .sck   (spi_sck),
    .mosi  (mosi_raw),
    .rx    (rx)
  );

  assign spi_mosi        = mosi_raw & busy;
  assign bus.mem_op_done = done_q;
  assign bus.data_out    = dout_q;

  // flash writes skip the bus and go straight to the done cycle
  always_comb begin
    state_n = state;
    op_n    = op_q;
    sel_n   = sel_q;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mem_ctrl_op != MEM_NOP) begin
          op_n  = bus.mem_ctrl_op;
          sel_n = bus.addr_sel;
        end
        unique case (1'b1)
          (bus.mem_ctrl_op == MEM_NOP): ;
          (bus.mem_ctrl_op == MEM_WRITE &&
           bus.addr_sel == PC):
            state_n = FINISH;
          default: begin
            start   = 1'b1;
            state_n = SHIFT;
          end
        endcase
      end
      SHIFT:   if (last) state_n = FINISH;
      FINISH:  state_n = RELEASE;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      op_q           <= MEM_NOP;
      sel_q          <= PC;
      done_q         <= 1'b0;
      spi_cs_flash_n <= 1'b1;
      spi_cs_ram_n   <= 1'b1;
      dout_q         <= '0;
    end else begin
      state          <= state_n;
      op_q           <= op_n;
      sel_q          <= sel_n;
      done_q         <= (state_n == FINISH);
      spi_cs_flash_n <= !(state_n == SHIFT && sel_n == PC);
      spi_cs_ram_n   <= !(state_n == SHIFT && sel_n == MAR);
      if (state == SHIFT && last && op_q == MEM_READ)
        dout_q <= rx;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_spi.sv
// Bench: two responders (CLK_DIV 1 and 3) checked every
// cycle against a timing model plus directed literals.
module tb_mem_ctrl_spi;
  import mem_ctrl_spi_pkg::*;

  localparam int DIV [2] = '{1, 3};

  logic         clk;
  logic         rst_n [2];
  mem_ctrl_op_e op    [2];
  addr_sel_e    sel   [2];
  logic [15:0]  pc    [2];
  logic [15:0]  mar   [2];
  logic [7:0]   din   [2];
  logic [7:0]   dout  [2];
  logic         done  [2];
  logic         sck   [2];
  logic         mosi  [2];
  logic         miso  [2];
  logic         csf   [2];
  logic         csr   [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_ctrl_spi_if #(.ADDR_WIDTH(16), .DATA_BUS_WIDTH(8)) bus ();
    assign bus.mem_ctrl_op = op[g];
    assign bus.addr_sel    = sel[g];
    assign bus.pc_addr     = pc[g];
    assign bus.mar_addr    = mar[g];
    assign bus.data_in     = din[g];
    assign dout[g]         = bus.data_out;
    assign done[g]         = bus.mem_op_done;
    mem_ctrl_spi #(
      .ADDR_WIDTH(16), .DATA_BUS_WIDTH(8),
      .CLK_DIV(g == 0 ? 1 : 3)
    ) dut (
      .clock(clk), .reset(rst_n[g]), .bus(bus.slave),
      .spi_sck(sck[g]), .spi_mosi(mosi[g]),
      .spi_miso(miso[g]), .spi_cs_flash_n(csf[g]),
      .spi_cs_ram_n(csr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string n, int d,
                              logic [63:0] g, logic [63:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h",
               n, d, cyc, g, e);
    end
  endfunction

  // Behavioural model: per transaction, outputs follow from
  // the cycle offset k since acceptance.
  bit          act   [2];
  bit          rd    [2];
  int          dur   [2];
  int          t0    [2];
  int          ready [2] = '{0, 0};
  addr_sel_e   tgt   [2];
  logic [39:0] fr    [2];
  logic [7:0]  mbyte [2];
  logic [7:0]  edout [2];
  logic        edone [2], ecsf [2], ecsr [2];
  logic        esck  [2], emosi [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int k, ph;
      logic [15:0] a;
      if (!rst_n[d]) begin
        act[d]   = 0;
        ready[d] = cyc + 1;
        edout[d] = 8'h00;
      end else if (!act[d] && cyc >= ready[d] &&
                   op[d] != MEM_NOP) begin
        act[d] = 1;
        t0[d]  = cyc;
        rd[d]  = (op[d] == MEM_READ);
        tgt[d] = sel[d];
        dur[d] = (op[d] == MEM_WRITE && sel[d] == PC)
               ? 0 : 80 * DIV[d];
        a      = (sel[d] == MAR) ? mar[d] : pc[d];
        fr[d]  = {(op[d] == MEM_WRITE) ? 8'h02 : 8'h03,
                  8'h00, a, din[d]};
      end
      edone[d] = 0; ecsf[d] = 1; ecsr[d] = 1;
      esck[d]  = 0; emosi[d] = 0;
      if (act[d]) begin
        k = cyc + 1 - t0[d];
        if (k <= dur[d]) begin
          if (tgt[d] == PC) ecsf[d] = 0;
          else              ecsr[d] = 0;
          ph       = (k - 1) / DIV[d];
          esck[d]  = (ph % 2) == 1;
          emosi[d] = fr[d][39 - ph / 2];
        end else begin
          edone[d] = 1;
          if (rd[d]) edout[d] = mbyte[d];
          act[d]   = 0;
          ready[d] = cyc + 3;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        chk("done", d, done[d], edone[d]);
        chk("cs_flash_n", d, csf[d], ecsf[d]);
        chk("cs_ram_n", d, csr[d], ecsr[d]);
        chk("sck", d, sck[d], esck[d]);
        chk("mosi", d, mosi[d], emosi[d]);
        chk("data_out", d, dout[d], edout[d]);
      end
    end
  end

  // SPI slave: data byte on the last 8 rising edges,
  // noise on MISO elsewhere; MOSI captured at each rise.
  int          rises [2] = '{0, 0};
  int          r0    [2], r1 [2];
  logic [39:0] cap   [2];
  logic        sck_q [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (csf[d] && csr[d]) begin
        rises[d] = 0;
      end else if (sck[d] && !sck_q[d]) begin
        cap[d] = {cap[d][38:0], mosi[d]};
        if (rises[d] == 0) r0[d] = cyc;
        if (rises[d] == 1) r1[d] = cyc;
        rises[d]++;
      end
      sck_q[d] = sck[d];
      if (rises[d] >= 32 && rises[d] < 40)
        miso[d] = mbyte[d][39 - rises[d]];
      else
        miso[d] = 1'($urandom);
    end
  end

  task automatic xact(input int d, input mem_ctrl_op_e o,
                      input addr_sel_e s,
                      input logic [15:0] p, m,
                      input logic [7:0] dat, b,
                      input bit scr, hold,
                      output int tt, output int dc);
    @(negedge clk);
    op[d] = o; sel[d] = s; pc[d] = p; mar[d] = m;
    din[d] = dat; mbyte[d] = b;
    tt = cyc;
    dc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done[d]) begin
        dc = cyc;
        break;
      end
      if (scr) begin
        pc[d]  = 16'($urandom);
        mar[d] = 16'($urandom);
        din[d] = 8'($urandom);
        sel[d] = addr_sel_e'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) op[d] = MEM_NOP;
      end
    end
    if (dc < 0) chk("done_timeout", d, done[d], 1);
    if (!hold) op[d] = MEM_NOP;
    @(negedge clk);
    op[d] = MEM_NOP;
  endtask

  initial begin
    int t, dc, n;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 0; op[d] = MEM_NOP; sel[d] = PC;
      pc[d] = 0; mar[d] = 0; din[d] = 0; mbyte[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cs", d, {csf[d], csr[d]}, 2'b11);
      chk("rst_sck_mosi", d, {sck[d], mosi[d]}, 2'b00);
      chk("rst_done", d, done[d], 0);
      chk("rst_dout", d, dout[d], 8'h00);
      rst_n[d] = 1;
    end

    xact(0, MEM_READ, PC, 16'h0012, 16'h0, 8'h77, 8'hA5,
         0, 0, t, dc);
    chk("flash_rd_lat", 0, dc - t, 81);
    chk("flash_rd_data", 0, dout[0], 8'hA5);
    chk("flash_rd_frame", 0, cap[0][39:8], 32'h03000012);

    xact(0, MEM_WRITE, MAR, 16'h0, 16'h1234, 8'h5C, 8'h00,
         0, 0, t, dc);
    chk("ram_wr_lat", 0, dc - t, 81);
    chk("ram_wr_frame", 0, cap[0], 40'h020012345C);
    chk("ram_wr_dout", 0, dout[0], 8'hA5);

    xact(0, MEM_WRITE, PC, 16'h0040, 16'h0, 8'h11, 8'h00,
         0, 0, t, dc);
    chk("flash_wr_lat", 0, dc - t, 1);
    chk("flash_wr_dout", 0, dout[0], 8'hA5);

    xact(0, MEM_READ, PC, 16'h0012, 16'h0, 8'h00, 8'h5A,
         0, 1, t, dc);
    chk("hold_rd_data", 0, dout[0], 8'h5A);
    n = dc;
    xact(0, MEM_READ, PC, 16'h0013, 16'h0, 8'h00, 8'hC3,
         0, 0, t, dc);
    chk("rerd_start", 0, t - n, 2);
    chk("rerd_lat", 0, dc - t, 81);
    chk("rerd_frame", 0, cap[0][39:8], 32'h03000013);
    chk("rerd_data", 0, dout[0], 8'hC3);

    @(negedge clk);
    op[0] = MEM_READ; sel[0] = PC; pc[0] = 16'h0021;
    mbyte[0] = 8'hE7;
    for (n = 0; n < 200 && rises[0] != 21; n++)
      @(negedge clk);
    chk("abort_reach", 0, rises[0], 21);
    rst_n[0] = 0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen |= done[0];
    end
    rst_n[0] = 1;
    op[0] = MEM_NOP;
    repeat (3) begin
      @(negedge clk);
      seen |= done[0];
    end
    chk("abort_nodone", 0, seen, 0);
    chk("abort_cs", 0, {csf[0], csr[0]}, 2'b11);
    xact(0, MEM_READ, PC, 16'h0030, 16'h0, 8'h00, 8'h96,
         0, 0, t, dc);
    chk("post_abort_lat", 0, dc - t, 81);
    chk("post_abort_data", 0, dout[0], 8'h96);

    xact(1, MEM_READ, MAR, 16'h0, 16'h00FF, 8'h00, 8'h3C,
         0, 0, t, dc);
    chk("div3_lat", 1, dc - t, 241);
    chk("div3_period", 1, r1[1] - r0[1], 6);
    chk("div3_frame", 1, cap[1][39:8], 32'h030000FF);
    chk("div3_data", 1, dout[1], 8'h3C);

    for (int i = 0; i < 40; i++) begin
      int d;
      mem_ctrl_op_e o;
      addr_sel_e s;
      d = i % 2;
      o = mem_ctrl_op_e'($urandom_range(1, 2));
      s = addr_sel_e'($urandom_range(0, 1));
      xact(d, o, s, 16'($urandom), 16'($urandom),
           8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), t, dc);
      chk("rand_lat", d, dc - t,
          (o == MEM_WRITE && s == PC) ? 1 : 80 * DIV[d] + 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_spi.md
Name: mem_ctrl_spi

Overview:
- Memory responder for the CPU control FSM's request/done handshake.
- Takes `mem_ctrl_op` and `addr_sel`, picks the address: PC selects external SPI flash, MAR selects external SPI RAM.
- Runs one mode-0 SPI byte transaction, then pulses `mem_op_done` for one cycle.
- Read data is held on `data_out` for the datapath bus mux.

Parameters:
- ADDR_WIDTH, 16, width of the PC and MAR address inputs; zero-extended to 24 SPI address bits.
- DATA_BUS_WIDTH, 8, data byte width; fixed at 8 for SPI framing.
- CLK_DIV, 1, SCK half-period in clock cycles; must be ≥1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- mem_ctrl_op  in  mem_ctrl_op_e (2)  MEM_NOP / MEM_READ / MEM_WRITE request, held by the requester until done
- addr_sel  in  addr_sel_e (1)  PC = flash, MAR = RAM
- pc_addr  in  ADDR_WIDTH  program counter value
- mar_addr  in  ADDR_WIDTH  memory address register value
- data_in  in  8  write data (ALU output)
- data_out  out  8  last read byte, held until the next read completes
- mem_op_done  out  1  one-cycle completion pulse
- spi_sck  out  1  SPI clock, idle low
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in
- spi_cs_flash_n  out  1  flash chip select, active low
- spi_cs_ram_n  out  1  RAM chip select, active low

Behaviour:
- Reset is synchronous, active-low, on `clock`.
  - Reset values: state IDLE, `spi_cs_flash_n`=1, `spi_cs_ram_n`=1, `spi_sck`=0, `spi_mosi`=0, `mem_op_done`=0, `data_out`=0, bit counter 0.
  - Reset asserted mid-transaction aborts immediately: CS high, no done pulse.
- States: IDLE, SHIFT, FINISH, RELEASE.
- IDLE:
  - `mem_ctrl_op`=MEM_NOP: stay.
  - READ, or WRITE with `addr_sel`=MAR (call this cycle T): latch op, target, address (`pc_addr` or `mar_addr`) and `data_in`.
  - Load the 40-bit frame: cmd byte (READ 0x03, WRITE 0x02), 24-bit address MSB-first, data byte (`data_in` for WRITE, don't-care for READ).
  - Registered outputs at the T/T+1 edge: selected CS low, `spi_mosi`=frame bit 39, `spi_sck`=0; go to SHIFT.
- WRITE with `addr_sel`=PC (flash write) is illegal:
  - `mem_op_done`=1 in T+1, no CS activity, `data_out` unchanged.
  - Go to RELEASE.
- SHIFT, per bit:
  - CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - On the low→high transition, sample `spi_miso` into the read shift register.
  - On the high→low transition, present the next frame bit on MOSI.
  - Bits are MSB-first; only the last 8 sampled bits form the read byte.
  - After bit 0's high phase: SCK low, go to FINISH.
  - With CLK_DIV=1 this gives 80 SHIFT cycles, T+1..T+80.
- FINISH (cycle T+80·CLK_DIV+1):
  - CS high, `mem_op_done`=1.
  - READ: `data_out` = sampled byte, visible in this same cycle.
  - Go to RELEASE.
- RELEASE: `mem_op_done`=0; `mem_ctrl_op` is ignored for this cycle, because the requester's registered op may still read non-NOP; go to IDLE.
- Latched operands: `mem_ctrl_op`, `addr_sel` and addresses changing after acceptance are ignored; the transaction completes as latched, even if op drops to NOP.
- A new request is accepted at the earliest two cycles after the `mem_op_done` pulse.
- Only one CS is low at any time; MOSI is held 0 whenever both CS are high.

Decomposition:
- Shared package:
  - `mem_ctrl_op_e` and `addr_sel_e` already exist and are reused.
  - Add `SPI_CMD_READ`=8'h03 and `SPI_CMD_WRITE`=8'h02.
  - Add the `mem_ctrl_spi_state` enum (`/*verilator public*/`).
- One sub-module: `spi_shift_engine`.
  - Contains the CLK_DIV counter, SCK generation, 40-bit TX shift register, 8-bit RX shift register and bit counter.
  - Interface: start / busy / last.
- The top level holds the FSM, operand latching, CS select and the done pulse.

Test Plan:
- Flash read, `pc_addr`=0x0012, MISO model returns 0xA5, CLK_DIV=1 → MOSI 03 00 00 12, only `spi_cs_flash_n` low, `mem_op_done` exactly in T+81, `data_out`=0xA5.
- RAM write, `mar_addr`=0x1234, `data_in`=0x5C → MOSI 02 00 12 34 5C on `spi_cs_ram_n`, done in T+81, `data_out` unchanged.
- Flash write (WRITE+PC) → done in T+1, both CS stay high, SCK stays low.
- Requester holds READ one cycle after done, then NOP, then READ at `pc_addr`=0x0013 → no re-accept during RELEASE; second transaction starts and reads address 0x13.
- Reset low during SHIFT bit 20 → both CS high, SCK 0, done never asserted; a following read completes normally.
- CLK_DIV=3, RAM read MAR=0x00FF, MISO 0x3C → SCK period 6 cycles, done in T+241, `data_out`=0x3C.
